alu_wide_seq: RTL and testbench

Multi-limb add/subtract sequencer for the execute stage. It time-multiplexes the existing 32-bit combinational ALU over N_WORDS cycles to perform N_WORDS×32-bit ADD/SUB. It chains carry/borrow between limbs, accumulates the Z flag, and returns a full-width result with a 4-bit status {N,Z,C,V}. The ALU stays a separate instance: this block drives its operand/command inputs and samples its result/SR outputs.

---
 rtl/alu_wide_seq.sv | 135 +++++++++++++
 tb/tb_alu_wide_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: multi-limb ADD/SUB sequencer driving an external 32-bit ALU.
// One 32-bit limb is processed per cycle, lowest limb first. Carry/borrow is
// chained between limbs and the Z flag is accumulated. The full-width result
// and {N,Z,C,V} status are published only when the last limb is captured.
module alu_wide_seq #(
  parameter int N_WORDS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic                   use_c,
  input  logic                   c_in,
  input  logic [N_WORDS*32-1:0]  a,
  input  logic [N_WORDS*32-1:0]  b,
  output logic                   busy,
  output logic                   done,
  output logic [N_WORDS*32-1:0]  result,
  output logic [3:0]             sr,
  output logic [31:0]            alu_in1,
  output logic [31:0]            alu_in2,
  output logic [3:0]             alu_cmd,
  output logic                   alu_cin,
  output logic                   alu_vin,
  input  logic [31:0]            alu_result,
  input  logic [3:0]             alu_sr
);

  localparam int W     = N_WORDS * 32;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_WORDS - 1);

  localparam logic [3:0] CMD_ADD = 4'd2;
  localparam logic [3:0] CMD_ADC = 4'd3;
  localparam logic [3:0] CMD_SUB = 4'd4;
  localparam logic [3:0] CMD_SBC = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             z_acc;
  logic             op_lat;
  logic             use_c_lat;
  logic [W-1:0]     a_lat;
  logic [W-1:0]     b_lat;
  logic [W-1:0]     res_acc;
  logic [W-1:0]     res_nxt;
  logic             accept;
  logic             last;

  // A new request is taken only when not already sequencing limbs.
  assign accept  = start && (state != S_RUN);
  assign last    = (idx == LAST);
  assign alu_vin = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: status flags and ALU drive; the ALU sees zeros outside RUN.
  // The ALU's SBC subtracts ~Cin while its Cout means borrow, so the
  // borrow register is inverted on the way in for subtraction.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    alu_cmd = 4'd0;
    alu_cin = 1'b0;
    alu_in1 = 32'd0;
    alu_in2 = 32'd0;
    case (state)
      S_RUN: begin
        busy    = 1'b1;
        alu_in1 = a_lat[int'(idx)*32 +: 32];
        alu_in2 = b_lat[int'(idx)*32 +: 32];
        if (idx == '0) alu_cmd = op_lat ? (use_c_lat ? CMD_SBC : CMD_SUB)
                                        : (use_c_lat ? CMD_ADC : CMD_ADD);
        else           alu_cmd = op_lat ? CMD_SBC : CMD_ADC;
        alu_cin = op_lat ? ~carry : carry;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Working result with the current limb merged in.
  always_comb begin
    res_nxt = res_acc;
    res_nxt[int'(idx)*32 +: 32] = alu_result;
  end

  // Operand latch, limb index, carry/Z chaining and final result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      z_acc  <= 1'b1;
      result <= '0;
      sr     <= 4'd0;
    end else if (accept) begin
      a_lat     <= a;
      b_lat     <= b;
      op_lat    <= op;
      use_c_lat <= use_c;
      carry     <= c_in;
      idx       <= '0;
      z_acc     <= 1'b1;
    end else if (state == S_RUN) begin
      res_acc <= res_nxt;
      carry   <= alu_sr[1];
      z_acc   <= z_acc & alu_sr[2];
      idx     <= last ? '0 : idx + 1'b1;
      if (last) begin
        result <= res_nxt;
        sr     <= {alu_sr[3], z_acc & alu_sr[2], alu_sr[1], alu_sr[0]};
      end
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq (N_WORDS=2) with a behavioural 32-bit ALU attached.
// Expected results come from whole-operand 64-bit arithmetic.
module tb_alu_wide_seq;

  localparam int NW = 2;
  localparam int W  = NW * 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic          use_c = 1'b0;
  logic          c_in = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [3:0]    sr;
  logic [31:0]   alu_in1;
  logic [31:0]   alu_in2;
  logic [3:0]    alu_cmd;
  logic          alu_cin;
  logic          alu_vin;
  logic [31:0]   alu_result;
  logic [3:0]    alu_sr;

  alu_wide_seq #(.N_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .use_c(use_c), .c_in(c_in),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .sr(sr),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
    .alu_vin(alu_vin), .alu_result(alu_result), .alu_sr(alu_sr)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU: ADD/ADC/SUB/SBC, Cout = carry (add) or borrow (sub).
  logic [32:0] alu_s;
  logic        alu_v;
  always_comb begin
    alu_s = '0;
    alu_v = 1'b0;
    case (alu_cmd)
      4'd2: alu_s = {1'b0, alu_in1} + {1'b0, alu_in2};
      4'd3: alu_s = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_cin};
      4'd4: alu_s = {1'b0, alu_in1} - {1'b0, alu_in2};
      4'd5: alu_s = {1'b0, alu_in1} - {1'b0, alu_in2} - {32'd0, ~alu_cin};
      default: alu_s = '0;
    endcase
    if (alu_cmd == 4'd2 || alu_cmd == 4'd3)
      alu_v = (alu_in1[31] == alu_in2[31]) && (alu_s[31] != alu_in1[31]);
    else if (alu_cmd == 4'd4 || alu_cmd == 4'd5)
      alu_v = (alu_in1[31] != alu_in2[31]) && (alu_s[31] != alu_in1[31]);
    alu_result = alu_s[31:0];
    alu_sr     = {alu_s[31], alu_s[31:0] == 32'd0, alu_s[32], alu_v};
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Whole-width reference: {N,Z,C,V, result}; C is carry for ADD, borrow for SUB.
  function automatic logic [67:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic o, input logic u, input logic ci);
    logic [W:0] s;
    logic       cc;
    logic       v;
    cc = u & ci;
    if (!o) begin
      s = {1'b0, x} + {1'b0, y} + (W+1)'(cc);
      v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    end else begin
      s = {1'b0, x} - {1'b0, y} - (W+1)'(cc);
      v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    end
    return {s[W-1], s[W-1:0] == '0, s[W], v, s[W-1:0]};
  endfunction

  logic [67:0]  expq[$];
  logic [W-1:0] last_res = '0;
  logic [3:0]   last_sr  = '0;
  logic         rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= rst;

  // Compare process: every cycle, result/sr against the model or the held value.
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst_seen) begin
      expq.delete();
      last_res = '0;
      last_sr  = '0;
      chk("rst_result", result, '0);
      chk("rst_sr", 64'(sr), '0);
      chk("rst_busy", 64'(busy), '0);
      chk("rst_done", 64'(done), '0);
    end else if (done) begin
      chk("done_not_busy", 64'(busy), '0);
      if (expq.size() == 0) begin
        chk("unexpected_done", 64'(done), '0);
      end else begin
        e = expq.pop_front();
        chk("result", result, e[63:0]);
        chk("sr", 64'(sr), 64'(e[67:64]));
        last_res = e[63:0];
        last_sr  = e[67:64];
      end
    end else begin
      chk("result_hold", result, last_res);
      chk("sr_hold", 64'(sr), 64'(last_sr));
    end
    if (!busy)
      chk("alu_idle", {27'd0, alu_cmd, alu_cin, alu_in1}, '0);
    if (!busy)
      chk("alu_idle_in2", 64'(alu_in2), '0);
    chk("alu_vin", 64'(alu_vin), '0);
  end

  logic [3:0] tr_cmd [8];
  logic       tr_cin [8];
  int         tr_n;

  // Present a request now (start is sampled at the next rising edge).
  task automatic launch_now(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic o, input logic u, input logic ci);
    a = x; b = y; op = o; use_c = u; c_in = ci; start = 1'b1;
    expq.push_back(model(x, y, o, u, ci));
  endtask

  // Consume the accepting edge, then follow the operation to done.
  task automatic wait_done(output int lat);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_after_start", 64'(done), '0);
    lat  = 1;
    tr_n = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      if (busy && tr_n < 8) begin
        tr_cmd[tr_n] = alu_cmd;
        tr_cin[tr_n] = alu_cin;
        tr_n++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic o, input logic u, input logic ci, output int lat);
    @(posedge clk);
    #1 launch_now(x, y, o, u, ci);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_cmd", 64'(alu_cmd), '0);

    // ADD with carry across the limb boundary.
    do_op(64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, lat);
    chk("t1_lat", 64'(lat), 64'd3);
    chk("t1_cmd0", 64'(tr_cmd[0]), 64'd2);
    chk("t1_cmd1", 64'(tr_cmd[1]), 64'd3);
    chk("t1_result", result, 64'h00000001_00000000);
    chk("t1_sr", 64'(sr), 64'h0);

    // SUB with borrow propagating into the high limb.
    do_op(64'd0, 64'd1, 1'b1, 1'b0, 1'b0, lat);
    chk("t2_cmd0", 64'(tr_cmd[0]), 64'd4);
    chk("t2_cmd1", 64'(tr_cmd[1]), 64'd5);
    chk("t2_cin1", 64'(tr_cin[1]), 64'd0);
    chk("t2_result", result, 64'hFFFFFFFF_FFFFFFFF);
    chk("t2_sr", 64'(sr), 64'hA);

    // Signed overflow.
    do_op(64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, lat);
    chk("t3_result", result, 64'h80000000_00000000);
    chk("t3_sr", 64'(sr), 64'h9);

    // Z accumulation.
    do_op(64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b1, 1'b0, 1'b0, lat);
    chk("t4_result", result, '0);
    chk("t4_sr", 64'(sr), 64'h4);
    do_op(64'h00000001_00000000, 64'd0, 1'b0, 1'b0, 1'b0, lat);
    chk("t5_sr", 64'(sr), 64'h0);

    // Incoming carry on the lowest limb.
    do_op(64'd0, 64'd0, 1'b0, 1'b1, 1'b1, lat);
    chk("t6_cmd0", 64'(tr_cmd[0]), 64'd3);
    chk("t6_cin0", 64'(tr_cin[0]), 64'd1);
    chk("t6_result", result, 64'd1);

    // start held through RUN with different operands is ignored.
    @(posedge clk);
    #1 launch_now(64'd5, 64'd7, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 a = 64'hDEAD_BEEF_0000_1111; b = 64'h1234; op = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_result", result, 64'd12);

    // Back-to-back: new start in the DONE cycle.
    do_op(64'd100, 64'd1, 1'b1, 1'b0, 1'b0, lat);
    launch_now(64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    chk("t8_lat", 64'(lat), 64'd3);
    chk("t8_result", result, '0);
    chk("t8_sr", 64'(sr), 64'h6);

    // Reset in the middle of RUN.
    @(posedge clk);
    #1 launch_now(64'h11, 64'h22, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t9_busy", 64'(busy), '0);
    chk("t9_done", 64'(done), '0);
    chk("t9_result", result, '0);
    chk("t9_sr", 64'(sr), '0);
    chk("t9_cmd", 64'(alu_cmd), '0);
    rst = 1'b0;

    // Randomized operations with occasional idle gaps and back-to-back starts.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: y = x;
        1: x = {32'd0, 32'hFFFFFFFF};
        2: y = '0;
        3: x = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      if (i % 7 == 3) begin
        launch_now(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        wait_done(lat);
      end else begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        do_op(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), lat);
      end
      chk("rand_lat", 64'(lat), 64'd3);
    end

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
